// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and baud divider arithmetic.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_rx_state_e;

    // Clocks per bit (half = 0) or per half bit (half = 1); used by both directions.
    function automatic int baud_cnt(input int clk_fre, input int baud_rate, input bit half);
        int bps;
        bps = clk_fre / baud_rate;
        return half ? bps / 2 : bps;
    endfunction

endpackage

// File: rtl/rxd_clk.sv
// Receive baud generator: after start, bps_tick fires at the half-bit point, then every BPS_CNT cycles.
// Tick is combinational from the counter; no backpressure, the counter free-runs while run is high.
module rxd_clk #(
    parameter int BPS_CNT  = 10,
    parameter int HALF_CNT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic bps_tick
);

    localparam int CW = $clog2(BPS_CNT);

    logic [CW-1:0] cnt;
    logic          first;

    assign bps_tick = run && !start &&
                      (cnt == (first ? CW'(HALF_CNT - 1) : CW'(BPS_CNT - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (start) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (run) begin
            if (bps_tick) begin
                cnt   <= '0;
                first <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, strobes one cycle after the stop sample; no backpressure, rx_valid is a pulse.
// Define UART_RX_PARITY_EN to add a parity slot, PARITY_ODD and the rx_parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    , output logic               rx_parity_err
`endif
);

    localparam int BPS_CNT  = baud_cnt(CLK_FRE, BAUD_RATE, 1'b0);
    localparam int HALF_CNT = baud_cnt(CLK_FRE, BAUD_RATE, 1'b1);
    localparam int BW       = $clog2(DATA_BITS);

    if (BPS_CNT < 4) begin : g_bps_check
        $error("uart_rx: CLK_FRE/BAUD_RATE must be at least 4");
    end

    logic                 sync1, rx_s, rx_q, fall;
    logic                 start, run, bps_tick;
    uart_rx_state_e       state, state_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt, data_nxt;
    logic                 valid_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_nxt, perr_nxt;
`endif

    assign fall    = rx_q & ~rx_s;
    assign run     = (state != IDLE);
    assign rx_busy = (state != IDLE);

    rxd_clk #(
        .BPS_CNT  (BPS_CNT),
        .HALF_CNT (HALF_CNT)
    ) u_rxd_clk (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .run      (run),
        .bps_tick (bps_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= 1'b1;
            rx_s         <= 1'b1;
            rx_q         <= 1'b1;
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            sync1        <= rxd;
            rx_s         <= sync1;
            rx_q         <= rx_s;
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift        <= shift_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad       <= par_bad_nxt;
            rx_parity_err <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        data_nxt    = rx_data;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        start       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Only a true 1->0 transition starts a frame, so a held-low line stays idle.
                if (fall) begin
                    start       = 1'b1;
                    state_nxt   = START;
                    bit_cnt_nxt = '0;
                end
            end
            START: begin
                if (bps_tick) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bps_tick) begin
                    shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bps_tick) begin
                    par_bad_nxt = ((^shift) ^ rx_s) != PARITY_ODD;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (bps_tick) begin
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt  = par_bad;
`endif
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; expected strobes are queued as frames are sent.
// Define UART_RX_PARITY_EN to also exercise the even-parity slot.
module tb_uart_rx;

    localparam int CLK_FRE   = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DATA_BITS = 8;
    localparam int BPS       = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int busy_n     = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
        , .rx_parity_err (rx_parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) tick();
    endtask

    // Strobe lands 2 sync cycles + half bit + start/data/parity/stop slots + 1 register cycle after the start drive.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        exp_t e;
        e.at   = cyc + 2 + BPS / 2 + (DATA_BITS + 1 + PAR) * BPS + 1;
        e.ferr = !stop_v;
        e.data = stop_v ? d : last_good;
        e.perr = stop_v && (PAR != 0) && (par_v != ^d);
        if (stop_v) last_good = d;
        sb.push_back(e);
        hold(1'b0, BPS);
        for (int i = 0; i < 8; i++) hold(d[i], BPS);
        if (PAR != 0) hold(par_v, BPS);
        hold(stop_v, BPS);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (rx_valid || rx_frame_err)) begin
            chk("strobe_exclusive", 32'(rx_valid & rx_frame_err), 32'(0));
            compared++;
            assert (sb.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_strobe: observed strobe at cycle %0d expected none", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("frame_err", 32'(rx_frame_err), 32'(e.ferr));
                chk("valid", 32'(rx_valid), 32'(!e.ferr));
                chk("data", 32'(rx_data), 32'(e.data));
                chk("strobe_cycle", 32'(cyc), 32'(e.at));
`ifdef UART_RX_PARITY_EN
                chk("parity_err", 32'(rx_parity_err), 32'(e.perr));
`endif
            end
        end
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_data", 32'(rx_data), 32'(0));
        chk("reset_valid", 32'(rx_valid), 32'(0));
        chk("reset_ferr", 32'(rx_frame_err), 32'(0));
        chk("reset_busy", 32'(rx_busy), 32'(0));
        hold(1'b1, 20);

        // Single frame
        send_frame(8'hA5, 1'b1, ^8'hA5);
        hold(1'b1, 20);

        // Back-to-back frames, one stop bit
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        hold(1'b1, 20);

        // Start glitch of 3 cycles must abort at the half-bit check
        rxd = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) rxd = 1'b1;
            if (rx_busy) busy_n++;
            tick();
        end
        chk("glitch_busy_cycles", 32'(busy_n), 32'(5));
        hold(1'b1, 100);

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, ^8'h3C);
        hold(1'b0, 50 * BPS);
        chk("break_busy", 32'(rx_busy), 32'(0));
        chk("break_data_kept", 32'(rx_data), 32'(last_good));
        hold(1'b1, 30);
        send_frame(8'h11, 1'b1, ^8'h11);
        hold(1'b1, 20);

        // Reset in the middle of bit 4 of 0x5A (bit 4 is a 1)
        hold(1'b0, BPS);
        hold(1'b0, BPS);
        hold(1'b1, BPS);
        hold(1'b0, BPS);
        hold(1'b1, BPS);
        hold(1'b1, BPS / 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_data", 32'(rx_data), 32'(0));
        chk("midrst_valid", 32'(rx_valid), 32'(0));
        chk("midrst_ferr", 32'(rx_frame_err), 32'(0));
        chk("midrst_busy", 32'(rx_busy), 32'(0));
        last_good = 8'h00;
        hold(1'b1, 150);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        hold(1'b1, 20);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs a parity bit of 1
        send_frame(8'h07, 1'b1, 1'b0);
        hold(1'b1, 20);
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 20);
`endif

        chk("final_data", 32'(rx_data), 32'(last_good));
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path: the receiver counterpart to the existing transmit-side baud clock and transmitter.
- Recovers 8N1 frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit) from the asynchronous serial line `rxd`.
- Delivers each byte with a one-cycle valid strobe, and flags framing errors.
- Sits between the board pin and the receive-side user logic (FIFO/loopback).

Parameters:
- CLK_FRE, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line baud rate
- DATA_BITS, 8, data bits per frame (5..8)

Ports:
- clk  in  1  system clock; one clock domain, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial input; idle high
- rx_data  out  DATA_BITS  last good received byte; holds until next good frame
- rx_valid  out  1  one-cycle pulse, rx_data updated this cycle
- rx_frame_err  out  1  one-cycle pulse, stop bit sampled low
- rx_busy  out  1  high from start-edge detection until return to IDLE

Behaviour:
- Constants:
  - BPS_CNT = CLK_FRE/BAUD_RATE (integer divide).
  - HALF_CNT = BPS_CNT/2.
  - BPS_CNT < 4 is illegal; flag it at elaboration with $error.
- Synchronizer:
  - rxd passes through a 2-flop synchronizer to give rx_s; both flops reset to 1.
  - rx_q is a 1-cycle delayed copy of rx_s.
  - Falling edge is defined as rx_q=1 and rx_s=0.
- Reset values:
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0.
  - state=IDLE, counters=0.
  - rst overrides everything in any state, including mid-frame. The partial frame is discarded with no strobe.
- States: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: rx_busy=0. On a falling edge, go to START, clear the baud counter, set rx_busy=1. Let T0 be the cycle in which the edge is seen.
  - START: sample rx_s when the baud counter reaches HALF_CNT-1 (cycle T0+HALF_CNT).
    - Sample = 0: go to DATA, restart the baud counter.
    - Sample = 1 (glitch): go to IDLE; no strobes.
  - DATA: sample every BPS_CNT cycles.
    - Bit i (0-based) is sampled at T0+HALF_CNT+(i+1)*BPS_CNT.
    - Bits shift into the shift register LSB first.
    - After bit DATA_BITS-1, go to STOP.
  - STOP: sample at T0+HALF_CNT+(DATA_BITS+1)*BPS_CNT.
    - Sample = 1: rx_data <= shift register and rx_valid=1 in the next cycle.
    - Sample = 0: rx_frame_err=1 in the next cycle; rx_data unchanged.
    - Either way, return to IDLE on the same transition. The remaining half stop bit is not waited for, so back-to-back frames are accepted.
- rx_valid and rx_frame_err:
  - Registered; never high together.
  - Each high exactly one cycle per frame.
- Break condition (line held low):
  - Causes exactly one rx_frame_err.
  - IDLE then waits for a true 1->0 edge, so a held-low line cannot retrigger.
- Edges while not in IDLE are ignored (no resync mid-frame).
- Baud counter width: $clog2(BPS_CNT). It wraps to 0 on each sample strobe.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP. Its sample is at bit slot DATA_BITS, and the stop sample moves one BPS_CNT later.
  - Parameter PARITY_ODD (default 0 = even) selects parity sense.
  - Output port rx_parity_err (1 bit, reset 0) pulses in the same cycle as rx_valid when parity mismatches. The byte is still delivered.
  - A framing error takes priority: the frame gives rx_frame_err only, and no rx_parity_err.
- Undefined: no PARITY state, no port, no PARITY_ODD parameter; behaviour exactly as above.

Decomposition:
- Package uart_pkg:
  - state enum typedef uart_rx_state_e.
  - function computing BPS_CNT/HALF_CNT from CLK_FRE and BAUD_RATE; shared with the transmit side.
- One sub-module rxd_clk:
  - Receive baud generator: clk, rst, start (restart, half-bit first period), run.
  - Output bps_tick: one-cycle strobe at the half-bit point first, then every BPS_CNT cycles.
  - The FSM stays in uart_rx.

Test Plan (CLK_FRE=1_000_000, BAUD_RATE=100_000 -> BPS_CNT=10, HALF_CNT=5):
1. Send 0xA5 (8N1).
   - rx_valid pulses once, rx_data=0xA5.
   - Pulse occurs at T0+5+9*10+1 = T0+96; rx_frame_err stays 0.
2. Two back-to-back frames 0x00 then 0xFF, stop bit only 1 bit long.
   - Two rx_valid pulses 100 cycles apart, with data 0x00 then 0xFF.
3. Glitch: rxd low for 3 cycles, then high.
   - Returns to IDLE at the half-bit check.
   - No rx_valid or rx_frame_err; rx_busy high for ~5 cycles only.
4. Frame 0x3C with stop bit driven 0, then line held low for 50 bit times.
   - Exactly one rx_frame_err; rx_data keeps its previous value.
   - No further strobes until the line returns high and a new frame 0x11 is received correctly.
5. Assert rst for 1 cycle during bit 4 of frame 0x5A.
   - All outputs return to reset values next cycle; no strobe for that frame.
   - The next clean frame 0x5A is received correctly.
6. With UART_RX_PARITY_EN, even parity: send 0x07 with parity bit 0 (wrong).
   - rx_valid and rx_parity_err pulse together; rx_data=0x07.
   - Repeat with parity bit 1: rx_parity_err stays 0.
